// File: rtl/right_shift_serializer.sv
// Parallel-in, LSB-first serial-out transmitter feeding a right-shift deserializer.
// Words are framed by out_valid/last; done pulses once in the cycle after each final bit.
module right_shift_serializer #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DEPTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             enable,
  output logic             out,
  output logic             out_valid,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg;
  logic [DEPTH-1:0] shreg_reg;
  logic [CW-1:0]    cnt_reg;
  logic             done_reg;

  logic final_bit;
  logic load_fire;

  // The final bit being consumed opens the load window so words chain with no bubble.
  assign final_bit  = (state_reg == SHIFT) && (cnt_reg == LAST_CNT) && enable;
  assign load_ready = !reset && ((state_reg == IDLE) || final_bit);
  assign load_fire  = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load_fire) begin
            shreg_reg <= load_data;
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          if (enable) begin
            if (cnt_reg == LAST_CNT) begin
              done_reg <= 1'b1;
              if (load_fire) begin
                shreg_reg <= load_data;
                cnt_reg   <= '0;
              end else begin
                shreg_reg <= '0;
                state_reg <= IDLE;
              end
            end else begin
              shreg_reg <= {1'b0, shreg_reg[DEPTH-1:1]};
              cnt_reg   <= cnt_reg + CW'(1);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          shreg_reg <= '0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign out       = shreg_reg[0];
  assign out_valid = (state_reg == SHIFT);
  assign busy      = (state_reg == SHIFT);
  assign last      = (state_reg == SHIFT) && (cnt_reg == LAST_CNT);
  assign done      = done_reg;

endmodule

// File: tb/tb_right_shift_serializer.sv
// Bench for right_shift_serializer: directed scenarios then random traffic, checked
// against a word/bit-index model and a loopback right-shift receiver.
module tb_right_shift_serializer;

  localparam int DEPTH = 8;

  logic             clk;
  logic             reset;
  logic [DEPTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             enable;
  logic             out;
  logic             out_valid;
  logic             last;
  logic             busy;
  logic             done;

  right_shift_serializer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .enable     (enable),
    .out        (out),
    .out_valid  (out_valid),
    .last       (last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback receiver: each consumed bit enters at the MSB and shifts right.
  logic [DEPTH-1:0] rx_word;
  always_ff @(posedge clk) begin
    if (enable && out_valid) rx_word <= {out, rx_word[DEPTH-1:1]};
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;

  // Model: the word in flight and which bit index is being presented.
  logic             m_active = 1'b0;
  logic [DEPTH-1:0] m_word = '0;
  int               m_idx = 0;
  logic             m_done = 1'b0;
  logic [DEPTH-1:0] m_done_word = '0;

  task automatic chk(input string tag, input logic [DEPTH-1:0] got, input logic [DEPTH-1:0] want);
    n_cmp++;
    assert (got === want)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic step(input logic r, input logic lv, input logic [DEPTH-1:0] d, input logic en);
    logic exp_ready;
    logic fin;
    reset = r; load_valid = lv; load_data = d; enable = en;
    #1;
    fin       = m_active && (m_idx == DEPTH - 1) && en;
    exp_ready = !r && (!m_active || fin);
    chk("out_valid",  DEPTH'(out_valid),  DEPTH'(m_active));
    chk("busy",       DEPTH'(busy),       DEPTH'(m_active));
    chk("out",        DEPTH'(out),        DEPTH'(m_active ? m_word[m_idx] : 1'b0));
    chk("last",       DEPTH'(last),       DEPTH'(m_active && (m_idx == DEPTH - 1)));
    chk("load_ready", DEPTH'(load_ready), DEPTH'(exp_ready));
    chk("done",       DEPTH'(done),       DEPTH'(m_done));
    if (m_done) begin
      n_done++;
      chk("loopback_word", rx_word, m_done_word);
    end
    // Advance the model across the coming edge.
    if (r) begin
      m_active = 1'b0; m_idx = 0; m_done = 1'b0;
    end else begin
      m_done = fin;
      if (fin) m_done_word = m_word;
      if (m_active && en) begin
        if (fin) begin
          if (lv) begin m_word = d; m_idx = 0; end
          else m_active = 1'b0;
        end else begin
          m_idx++;
        end
      end else if (!m_active && lv) begin
        m_word = d; m_idx = 0; m_active = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic             lv;
    logic [DEPTH-1:0] d;
    logic             accepted;
    int               done_before;

    reset = 1'b1; load_valid = 1'b0; load_data = '0; enable = 1'b0;
    @(posedge clk); #1;
    // Reset held with a load offered: reset wins.
    step(1'b1, 1'b1, 8'h77, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // 8'hA5 with enable held high.
    done_before = n_done;
    step(1'b0, 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("done_count_a5", DEPTH'(n_done - done_before), DEPTH'(1));

    // Same word with enable toggling: each bit held two cycles.
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00, (i % 2) == 0);

    // Back-to-back: 8'hFF then 8'h00 pending on load_valid.
    done_before = n_done;
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("done_count_b2b", DEPTH'(n_done - done_before), DEPTH'(2));

    // Loopback of 8'h3C (receiver checked when done is high).
    step(1'b0, 1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Reset after three bits of 8'hC3, then 8'h01.
    done_before = n_done;
    step(1'b0, 1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("done_after_reset", DEPTH'(n_done - done_before), DEPTH'(0));
    step(1'b0, 1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Backpressure: load_valid held while enable is low.
    step(1'b0, 1'b1, 8'h5A, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h96, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h96, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Random traffic; a pending offer keeps its data until accepted.
    lv = 1'b0; d = '0;
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic en;
      if (!lv) begin
        lv = ($urandom_range(0, 2) != 0);
        d  = DEPTH'($urandom);
      end
      en = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 199) == 0);
      accepted = lv && !r && (!m_active || (m_idx == DEPTH - 1 && en));
      step(r, lv, d, en);
      if (accepted || r) lv = 1'b0;
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);

    chk("random_words_completed", DEPTH'(n_done > 20), DEPTH'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/right_shift_serializer.md
Name: right_shift_serializer

Overview:
- Parallel-in, serial-out transmitter. It is the sending end of the team's serial-in right-shift deserializer, which inserts each bit at the MSB and shifts right.
- A DEPTH-bit word is accepted through a valid/ready load handshake and emitted LSB first, one bit per enable strobe.
- The receiver sees bit 0 first. After DEPTH shifts, bit 0 lands at the receiver's LSB, so the word is reconstructed unchanged.
- Bit framing is provided by out_valid and last. A done pulse marks word completion. Back-to-back words are supported without a bubble.

Parameters:
- DEPTH, 8, word width in bits; legal range DEPTH >= 2.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- load_data  input  DEPTH  parallel word to transmit.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word this cycle (combinational).
- enable  input  1  shift strobe; the current bit is consumed on a clock edge where enable=1 and out_valid=1.
- out  output  1  current serial bit, equal to shreg[0].
- out_valid  output  1  out carries a valid data bit.
- last  output  1  current bit is the final (MSB) bit of the word.
- busy  output  1  a word is loaded and not yet fully shifted (equals out_valid).
- done  output  1  one-cycle pulse, registered, in the cycle after the final bit is consumed.

Behaviour:
- State: FSM {IDLE, SHIFT}; shreg[DEPTH-1:0]; bit counter cnt, width clog2(DEPTH); done register.
- Reset, applied at the clock edge while reset=1:
  - state=IDLE; shreg=0; cnt=0; done=0.
  - Resulting outputs: out=0, out_valid=0, busy=0, last=0.
  - load_ready is forced to 0 while reset is high.
  - Reset mid-word discards the word; no done pulse is produced.
- load_ready = !reset && (state==IDLE || (state==SHIFT && cnt==DEPTH-1 && enable)).
- Handshake: a load occurs on an edge where load_valid && load_ready.
  - load_data must be held stable while load_valid is high and load_ready is low.
- IDLE:
  - out_valid=0, out=shreg[0] (0 after reset); enable is ignored.
  - On load: shreg<=load_data, cnt<=0, state<=SHIFT. The first bit appears on out in the next cycle.
- SHIFT:
  - out_valid=1, out=shreg[0], last=(cnt==DEPTH-1).
  - enable=0: hold shreg, cnt and state; out stays stable indefinitely.
  - enable=1, cnt<DEPTH-1: shreg<={1'b0, shreg[DEPTH-1:1]}, cnt<=cnt+1.
  - enable=1, cnt==DEPTH-1, final bit consumed:
    - done<=1 for the next cycle.
    - If load_valid=1 in the same cycle: shreg<=load_data, cnt<=0, stay in SHIFT. There is no idle gap, and bit 0 of the new word is on out in the next cycle.
    - Otherwise state<=IDLE and shreg<=0.
- done: high for exactly one cycle per completed word, including back-to-back words. It is cleared on every other edge.
- Latency:
  - Load edge to first valid bit: 1 cycle.
  - A word occupies exactly DEPTH enable strobes.
  - Minimum DEPTH cycles per word with enable held at 1.
- A load is never accepted in SHIFT before the final bit is being consumed; load_valid held high simply waits.
- Simultaneous reset and load: reset wins; the word is not accepted.
- Counter wrap: cnt never exceeds DEPTH-1. It returns to 0 only via a load.

Test Plan:
- Reset release, DEPTH=8, load_data=8'hA5, load_valid pulsed 1 cycle, enable=1 constant:
  - out sequence 1,0,1,0,0,1,0,1 over 8 cycles.
  - last high only on the 8th bit.
  - done pulses once in the cycle after; then out_valid=0 and load_ready=1.
- Same word with enable toggling 1-0 each cycle: each bit holds 2 cycles; the same 8-bit sequence results; done appears after 16 cycles.
- Back-to-back words: load 8'hFF, then hold load_valid with 8'h00 pending:
  - load_ready rises only with last && enable.
  - out gives 8 ones followed immediately by 8 zeros with no out_valid gap.
  - done pulses twice.
- Loopback: connect out to a serial-in right-shift receiver of DEPTH=8, with receiver enable = enable && out_valid; load 8'h3C -> receiver word = 8'h3C in the cycle done is high.
- Reset asserted after 3 bits of 8'hC3 -> next cycle out=0, out_valid=0, no done pulse; a new load of 8'h01 then transmits correctly (1,0,0,0,0,0,0,0).
- Backpressure: load_valid=1 held during SHIFT with enable=0 -> load_ready=0, no capture, shreg and out frozen until enable returns.
